// File: rtl/bhand_fifo.sv
// bhand_fifo: DEPTH-entry valid/ready elastic buffer.
// The head word is always held in a registered output stage (odata/odata_vld).
// Words behind it sit in a circular buffer. The input ready is registered
// from the next occupancy, so no combinational path crosses the block.
// Occupancy includes the output register.
// Because of that, the circular buffer never holds more than DEPTH-1 words.
// As a result, pointer equality alone means the buffer is empty.
module bhand_fifo #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 4,
   parameter int COUNT_WIDTH  = 3,
   parameter int ENABLE_COUNT = 1,
   parameter int AF_THRESH    = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [DATA_WIDTH-1:0]  idata,
   input  logic                   idata_vld,
   output logic                   idata_rdy,
   output logic [DATA_WIDTH-1:0]  odata,
   output logic                   odata_vld,
   input  logic                   odata_rdy,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   almost_full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   irdy_q, irdy_d;
   logic                   ovld_q, ovld_d;
   logic                   af_q, af_d;
   logic [DATA_WIDTH-1:0]  odata_q, odata_d;
   logic                   push, pop, mem_empty, out_load, mem_wr;

   // Next-state: refill the output stage from the buffer, or bypass an incoming
   // word straight into it when the buffer is empty; otherwise queue the push.
   always_comb begin
      push      = idata_vld & irdy_q;
      pop       = ovld_q & odata_rdy;
      mem_empty = (rd_ptr_q == wr_ptr_q);
      out_load  = ~ovld_q | pop;

      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ovld_d    = ovld_q;
      odata_d   = odata_q;
      mem_wr    = 1'b0;
      cnt_d     = cnt_q + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);

      if (out_load) begin
         if (!mem_empty) begin
            odata_d  = mem_q[rd_ptr_q];
            ovld_d   = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else if (push) begin
            odata_d = idata;
            ovld_d  = 1'b1;
         end else begin
            ovld_d = 1'b0;
         end
      end

      if (push && !(out_load && mem_empty)) begin
         mem_wr   = 1'b1;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      irdy_d = (cnt_d < COUNT_WIDTH'(DEPTH));
      af_d   = (ENABLE_COUNT != 0) && (cnt_d >= COUNT_WIDTH'(AF_THRESH));

      // flush wins over any handshake at the same edge; odata is left as-is
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovld_d   = 1'b0;
         irdy_d   = 1'b1;
         af_d     = 1'b0;
         mem_wr   = 1'b0;
      end
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         irdy_q   <= 1'b1;
         ovld_q   <= 1'b0;
         af_q     <= 1'b0;
         odata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         irdy_q   <= irdy_d;
         ovld_q   <= ovld_d;
         af_q     <= af_d;
         odata_q  <= odata_d;
      end
   end

   // Storage array; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem_q[wr_ptr_q] <= idata;
      end
   end

   assign idata_rdy   = irdy_q;
   assign odata_vld   = ovld_q;
   assign odata       = odata_q;
   assign count       = (ENABLE_COUNT != 0) ? cnt_q : '0;
   assign almost_full = af_q;

endmodule

// File: doc/bhand_fifo.md
Name: bhand_fifo

Overview:
- Parametrised successor to the single-entry buffered handshake: a DEPTH-entry valid/ready elastic buffer with registered input-ready and registered output.
- Sits between HLS-generated stream producers and consumers in the middleware.
- Decouples backpressure across multiple cycles.
- Adds an optional occupancy count, an almost-full flag and a synchronous flush.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
DEPTH, 4, number of storage entries; power of two, >=2
COUNT_WIDTH, 3, width of occupancy count; must equal log2(DEPTH)+1
ENABLE_COUNT, 1, 1 = count and almost_full driven from logic; 0 = both tied to 0
AF_THRESH, 3, almost_full asserts when occupancy >= AF_THRESH (1..DEPTH)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
flush  input  1  synchronous clear of all stored entries
idata  input  DATA_WIDTH  upstream payload
idata_vld  input  1  upstream valid
idata_rdy  output  1  upstream ready, driven directly from a flop
odata  output  DATA_WIDTH  downstream payload, driven directly from a flop
odata_vld  output  1  downstream valid, driven directly from a flop
odata_rdy  input  1  downstream ready
count  output  COUNT_WIDTH  entries held, including the output register
almost_full  output  1  count >= AF_THRESH

Behaviour:
- Reset (rst=0, asynchronous):
  - idata_rdy=1, odata_vld=0, odata=0, count=0, almost_full=0.
  - Read/write pointers cleared.
  - Deassertion is synchronised by the user; the block needs only glitch-free release.
- Handshakes:
  - push = idata_vld & idata_rdy; pop = odata_vld & odata_rdy, both sampled at the rising edge.
  - Payload and valid are held stable while valid is high and ready is low.
- Storage:
  - Circular buffer of DEPTH entries, with the head entry presented through a registered odata/odata_vld stage.
  - Total occupancy never exceeds DEPTH.
- Latency:
  - A word pushed at edge N into an empty buffer appears with odata_vld=1 after edge N (1 cycle).
  - No combinational path from idata/idata_vld to odata/odata_vld, or from odata_rdy to idata_rdy.
- idata_rdy = registered (next_count < DEPTH).
  - With count==DEPTH, a pop at edge N raises idata_rdy after edge N, so a push is possible at edge N+1.
  - A full buffer never takes a push and a pop at the same edge.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, FIFO order preserved, full throughput of 1 word/cycle.
- Simultaneous push and pop with count==1: the new word goes straight into the output register and odata_vld stays 1.
- Ordering: strict FIFO; no word lost, duplicated or reordered, including across pointer wrap-around at DEPTH.
- count:
  - next_count = count + push - pop, registered; never wraps.
  - almost_full is registered from next_count.
- flush=1 at an edge:
  - Clears pointers, count=0, odata_vld=0, idata_rdy=1, almost_full=0.
  - Any push or pop at the same edge is discarded.
  - odata value is don't-care after flush.
- ENABLE_COUNT=0: count and almost_full are held at 0; the flow-control logic is unchanged.
- Reset asserted mid-transfer: all state is cleared immediately; in-flight words are lost by design.

Test Plan:
1. Reset with rst=0 for 3 cycles, then release -> idata_rdy=1, odata_vld=0, count=0, almost_full=0.
2. Push 0x11,0x22,0x33,0x44 with odata_rdy=0 (DEPTH=4):
   - count rises 1,2,3,4; almost_full rises when count reaches 3.
   - idata_rdy=0 after the 4th push.
   - odata=0x11 with odata_vld=1 from the cycle after the first push.
3. From full, hold odata_rdy=1 and idata_vld=1 streaming 0x55..0x5C:
   - Output order is 0x11,0x22,0x33,0x44,0x55,... with no gaps once steady.
   - idata_rdy re-asserts 1 cycle after the first pop.
   - Pointers wrap at least twice.
4. Empty buffer, continuous push/pop of 0x00..0xFF with odata_rdy=1:
   - 1 word/cycle after a 1-cycle latency.
   - count stays at 1.
   - Output equals input delayed by one cycle.
5. Random idata_vld/odata_rdy with 10000 words -> scoreboard matches in order; count is always in 0..4; no push while idata_rdy=0 is accepted.
6. Two further events:
   - flush=1 with count=3 and a simultaneous push -> next cycle count=0, odata_vld=0, idata_rdy=1, pushed word dropped.
   - rst=0 asserted between clock edges -> outputs take reset values before the next edge.
